// File: rtl/cordic_sched_foc.sv
// cordic_sched_foc: shares one CORDIC rotator between the Park (ch0)
// and inverse Park (ch1) paths with round-robin arbitration and watchdog.
module cordic_sched_foc #(
  parameter int g_STD_IO_WIDTH = 18,
  parameter int g_TIMEOUT      = 64
) (
  input  logic                      sys_clk_i,
  input  logic                      reset_i,
  input  logic                      ch0_req_i,
  input  logic [g_STD_IO_WIDTH-1:0] ch0_x_i,
  input  logic [g_STD_IO_WIDTH-1:0] ch0_y_i,
  input  logic [g_STD_IO_WIDTH-1:0] ch0_theta_i,
  output logic                      ch0_ack_o,
  output logic                      ch0_valid_o,
  output logic [g_STD_IO_WIDTH-1:0] ch0_x_o,
  output logic [g_STD_IO_WIDTH-1:0] ch0_y_o,
  input  logic                      ch1_req_i,
  input  logic [g_STD_IO_WIDTH-1:0] ch1_x_i,
  input  logic [g_STD_IO_WIDTH-1:0] ch1_y_i,
  input  logic [g_STD_IO_WIDTH-1:0] ch1_theta_i,
  output logic                      ch1_ack_o,
  output logic                      ch1_valid_o,
  output logic [g_STD_IO_WIDTH-1:0] ch1_x_o,
  output logic [g_STD_IO_WIDTH-1:0] ch1_y_o,
  output logic                      cordic_start_o,
  output logic [g_STD_IO_WIDTH-1:0] cordic_x_o,
  output logic [g_STD_IO_WIDTH-1:0] cordic_y_o,
  output logic [g_STD_IO_WIDTH-1:0] cordic_theta_o,
  input  logic                      cordic_done_i,
  input  logic [g_STD_IO_WIDTH-1:0] cordic_x_i,
  input  logic [g_STD_IO_WIDTH-1:0] cordic_y_i,
  output logic                      busy_o,
  output logic                      err_o
);

  localparam int W = g_STD_IO_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_RESP
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic         last_grant;
  logic         grant;
  logic         grant_nxt;
  logic [7:0]   wd_cnt;
  logic         any_req;
  logic         timeout;
  logic [W-1:0] theta_sel;

  assign any_req   = ch0_req_i | ch1_req_i;
  // Contention goes to the channel not served last; otherwise the requester.
  assign grant_nxt = (ch0_req_i & ch1_req_i) ? ~last_grant : ch1_req_i;
  assign timeout   = (wd_cnt == 8'(g_TIMEOUT - 1));
  // The Park path rotates by -theta; wraparound gives the modulo for free.
  assign theta_sel = grant_nxt ? ch1_theta_i : (W'(0) - ch0_theta_i);

  // State register
  always_ff @(posedge sys_clk_i or posedge reset_i) begin
    if (reset_i) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; done has priority over the watchdog
  always_comb begin
    state_nxt = S_IDLE;
    unique case (state)
      S_IDLE:   state_nxt = any_req ? S_LAUNCH : S_IDLE;
      S_LAUNCH: state_nxt = S_WAIT;
      S_WAIT: begin
        if (cordic_done_i) state_nxt = S_RESP;
        else if (timeout)  state_nxt = S_IDLE;
        else               state_nxt = S_WAIT;
      end
      S_RESP:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Output decode: strobes routed to the granted channel
  always_comb begin
    cordic_start_o = 1'b0;
    ch0_ack_o      = 1'b0;
    ch1_ack_o      = 1'b0;
    ch0_valid_o    = 1'b0;
    ch1_valid_o    = 1'b0;
    busy_o         = 1'b1;
    err_o          = 1'b0;
    unique case (state)
      S_IDLE:   busy_o = 1'b0;
      S_LAUNCH: begin
        cordic_start_o = 1'b1;
        ch0_ack_o      = ~grant;
        ch1_ack_o      = grant;
      end
      S_WAIT:   err_o = ~cordic_done_i & timeout;
      S_RESP: begin
        ch0_valid_o = ~grant;
        ch1_valid_o = grant;
      end
      default:  busy_o = 1'b0;
    endcase
  end

  // Grant, rotator operands and watchdog counter
  always_ff @(posedge sys_clk_i or posedge reset_i) begin
    if (reset_i) begin
      grant          <= 1'b0;
      last_grant     <= 1'b1;
      wd_cnt         <= '0;
      cordic_x_o     <= '0;
      cordic_y_o     <= '0;
      cordic_theta_o <= '0;
    end else begin
      if (state == S_IDLE && any_req) begin
        grant          <= grant_nxt;
        last_grant     <= grant_nxt;
        cordic_x_o     <= grant_nxt ? ch1_x_i : ch0_x_i;
        cordic_y_o     <= grant_nxt ? ch1_y_i : ch0_y_i;
        cordic_theta_o <= theta_sel;
      end
      if (state == S_LAUNCH)    wd_cnt <= '0;
      else if (state == S_WAIT) wd_cnt <= wd_cnt + 8'd1;
    end
  end

  // Result registers only move on the WAIT-to-RESP edge
  always_ff @(posedge sys_clk_i or posedge reset_i) begin
    if (reset_i) begin
      ch0_x_o <= '0;
      ch0_y_o <= '0;
      ch1_x_o <= '0;
      ch1_y_o <= '0;
    end else if (state == S_WAIT && cordic_done_i) begin
      if (grant) begin
        ch1_x_o <= cordic_x_i;
        ch1_y_o <= cordic_y_i;
      end else begin
        ch0_x_o <= cordic_x_i;
        ch0_y_o <= cordic_y_i;
      end
    end
  end

endmodule

// File: tb/tb_cordic_sched_foc.sv
// tb_cordic_sched_foc: directed and randomized checks of the scheduler
// against a transaction-level model of arbitration, angles and results.
module tb_cordic_sched_foc;

  localparam int W     = 18;
  localparam int TO    = 64;
  localparam int TWO_W = 1 << W;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ch0_req = 1'b0;
  logic [W-1:0] ch0_x = '0, ch0_y = '0, ch0_theta = '0;
  logic         ch0_ack, ch0_valid;
  logic [W-1:0] ch0_xo, ch0_yo;
  logic         ch1_req = 1'b0;
  logic [W-1:0] ch1_x = '0, ch1_y = '0, ch1_theta = '0;
  logic         ch1_ack, ch1_valid;
  logic [W-1:0] ch1_xo, ch1_yo;
  logic         c_start;
  logic [W-1:0] c_xo, c_yo, c_to;
  logic         c_done = 1'b0;
  logic [W-1:0] c_xi = '0, c_yi = '0;
  logic         busy, err;

  int passes = 0;
  int total  = 0;

  int           m_last;
  logic [W-1:0] m_rx [2];
  logic [W-1:0] m_ry [2];

  always #5 clk = ~clk;

  cordic_sched_foc #(
    .g_STD_IO_WIDTH(W),
    .g_TIMEOUT(TO)
  ) dut (
    .sys_clk_i(clk),
    .reset_i(rst),
    .ch0_req_i(ch0_req),
    .ch0_x_i(ch0_x),
    .ch0_y_i(ch0_y),
    .ch0_theta_i(ch0_theta),
    .ch0_ack_o(ch0_ack),
    .ch0_valid_o(ch0_valid),
    .ch0_x_o(ch0_xo),
    .ch0_y_o(ch0_yo),
    .ch1_req_i(ch1_req),
    .ch1_x_i(ch1_x),
    .ch1_y_i(ch1_y),
    .ch1_theta_i(ch1_theta),
    .ch1_ack_o(ch1_ack),
    .ch1_valid_o(ch1_valid),
    .ch1_x_o(ch1_xo),
    .ch1_y_o(ch1_yo),
    .cordic_start_o(c_start),
    .cordic_x_o(c_xo),
    .cordic_y_o(c_yo),
    .cordic_theta_o(c_to),
    .cordic_done_i(c_done),
    .cordic_x_i(c_xi),
    .cordic_y_i(c_yi),
    .busy_o(busy),
    .err_o(err)
  );

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    total++;
    assert (o === e) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, o, e);
  endtask

  task automatic chk_res(input string tag);
    chk({tag, "_ch0x"}, 32'(ch0_xo), 32'(m_rx[0]));
    chk({tag, "_ch0y"}, 32'(ch0_yo), 32'(m_ry[0]));
    chk({tag, "_ch1x"}, 32'(ch1_xo), 32'(m_rx[1]));
    chk({tag, "_ch1y"}, 32'(ch1_yo), 32'(m_ry[1]));
  endtask

  task automatic model_reset();
    m_last = 1;
    for (int i = 0; i < 2; i++) begin
      m_rx[i] = '0;
      m_ry[i] = '0;
    end
  endtask

  // One grant: requests are already set; lat=0 means the rotator never answers
  task automatic serve(input int lat, input bit stray,
                       input logic [W-1:0] rx, input logic [W-1:0] ry);
    int           g;
    logic [W-1:0] ex, ey, et;
    bit           early;
    if (ch0_req && ch1_req) g = 1 - m_last;
    else                    g = ch1_req ? 1 : 0;
    if (g == 0) begin
      ex = ch0_x;
      ey = ch0_y;
      et = W'((TWO_W - int'(ch0_theta)) % TWO_W);
    end else begin
      ex = ch1_x;
      ey = ch1_y;
      et = ch1_theta;
    end
    @(negedge clk);
    chk("start", 32'(c_start), 1);
    chk("ack0", 32'(ch0_ack), 32'(g == 0));
    chk("ack1", 32'(ch1_ack), 32'(g == 1));
    chk("busy_launch", 32'(busy), 1);
    chk("cx", 32'(c_xo), 32'(ex));
    chk("cy", 32'(c_yo), 32'(ey));
    chk("ctheta", 32'(c_to), 32'(et));
    if (g == 0) ch0_req = 1'b0;
    else        ch1_req = 1'b0;
    m_last = g;
    if (stray) begin
      c_done = 1'b1;
      c_xi   = W'($urandom);
      c_yi   = W'($urandom);
    end
    early = 1'b0;
    if (lat == 0) begin
      for (int k = 1; k <= TO; k++) begin
        @(negedge clk);
        c_done = 1'b0;
        if (k < TO) early |= err | ch0_valid | ch1_valid | c_start;
        else begin
          chk("wd_err", 32'(err), 1);
          chk("wd_novalid", 32'(ch0_valid | ch1_valid), 0);
        end
      end
      chk("wd_early", 32'(early), 0);
      @(negedge clk);
      chk("wd_idle", 32'(busy), 0);
      chk("wd_errdrop", 32'(err), 0);
      chk("wd_novalid2", 32'(ch0_valid | ch1_valid), 0);
      chk_res("wd");
    end else begin
      for (int k = 1; k <= lat; k++) begin
        @(negedge clk);
        c_done = (k == lat);
        c_xi   = (k == lat) ? rx : W'($urandom);
        c_yi   = (k == lat) ? ry : W'($urandom);
        #1;
        if (k < lat) early |= err | ch0_valid | ch1_valid | c_start;
        else begin
          chk("done_noerr", 32'(err), 0);
          chk("done_novalid", 32'(ch0_valid | ch1_valid), 0);
        end
      end
      chk("wait_quiet", 32'(early), 0);
      @(negedge clk);
      c_done = 1'b0;
      m_rx[g] = rx;
      m_ry[g] = ry;
      chk("valid0", 32'(ch0_valid), 32'(g == 0));
      chk("valid1", 32'(ch1_valid), 32'(g == 1));
      chk_res("resp");
      @(negedge clk);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_valid", 32'(ch0_valid | ch1_valid), 0);
      chk_res("hold");
    end
  endtask

  task automatic rand_ops();
    ch0_x = W'($urandom); ch0_y = W'($urandom); ch0_theta = W'($urandom);
    ch1_x = W'($urandom); ch1_y = W'($urandom); ch1_theta = W'($urandom);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1);
  end

  initial begin
    int r;
    logic [W-1:0] th0 [3];
    th0[0] = 18'h10000;
    th0[1] = 18'h00000;
    th0[2] = 18'h3FFFF;
    model_reset();

    // Reset state, with both channels already requesting
    rand_ops();
    ch0_req = 1'b1;
    ch1_req = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_start", 32'(c_start), 0);
    chk("rst_ack", 32'({ch0_ack, ch1_ack}), 0);
    chk("rst_ctheta", 32'(c_to), 0);
    chk_res("rst");
    rst = 1'b0;

    // Contention from reset: ch0, ch1, then ch0 and ch1 again
    serve(5, 1'b0, W'($urandom), W'($urandom));
    serve(7, 1'b0, W'($urandom), W'($urandom));
    rand_ops();
    ch0_req = 1'b1;
    ch1_req = 1'b1;
    serve(3, 1'b0, W'($urandom), W'($urandom));
    serve(2, 1'b0, W'($urandom), W'($urandom));

    // Directed ch1 inverse Park, rotator answers 16 cycles after start
    ch1_x = 18'h01000; ch1_y = 18'h0; ch1_theta = 18'h10000;
    ch1_req = 1'b1;
    serve(16, 1'b0, 18'h00000, 18'h01000);
    chk("dir_ch1x", 32'(ch1_xo), 32'h0);
    chk("dir_ch1y", 32'(ch1_yo), 32'h01000);

    // ch0 angle negation corners, with a stray done in LAUNCH
    for (int i = 0; i < 3; i++) begin
      rand_ops();
      ch0_theta = th0[i];
      ch0_req = 1'b1;
      serve(4, 1'b1, W'($urandom), W'($urandom));
    end

    // Randomized traffic
    for (int i = 0; i < 12; i++) begin
      rand_ops();
      r = int'($urandom_range(3, 1));
      if (r[0]) ch0_req = 1'b1;
      if (r[1]) ch1_req = 1'b1;
      serve(int'($urandom_range(40, 2)), 1'($urandom),
            W'($urandom), W'($urandom));
    end
    while (ch0_req || ch1_req)
      serve(int'($urandom_range(10, 1)), 1'b0, W'($urandom), W'($urandom));

    // Watchdog abort, then a normal request
    rand_ops();
    ch0_req = 1'b1;
    serve(0, 1'b0, '0, '0);
    rand_ops();
    ch1_req = 1'b1;
    serve(9, 1'b0, W'($urandom), W'($urandom));

    // Done in the final WAIT cycle beats the watchdog
    rand_ops();
    ch0_req = 1'b1;
    serve(TO, 1'b0, W'($urandom), W'($urandom));

    // Stray done while idle
    @(negedge clk);
    c_done = 1'b1;
    @(negedge clk);
    c_done = 1'b0;
    chk("idle_stray_busy", 32'(busy), 0);
    chk("idle_stray_valid", 32'(ch0_valid | ch1_valid), 0);

    // Reset in WAIT, then a stale done
    rand_ops();
    ch1_req = 1'b1;
    @(negedge clk);
    ch1_req = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    chk("arst_busy", 32'(busy), 0);
    chk("arst_strobes",
        32'({c_start, ch0_ack, ch1_ack, ch0_valid, ch1_valid, err}), 0);
    chk("arst_cops", 32'(c_xo | c_yo | c_to), 0);
    chk_res("arst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    c_done = 1'b1;
    c_xi   = W'($urandom);
    c_yi   = W'($urandom);
    @(negedge clk);
    c_done = 1'b0;
    chk("stale_valid", 32'(ch0_valid | ch1_valid), 0);
    chk("stale_busy", 32'(busy), 0);
    chk_res("stale");

    // last_grant is back at 1: contention favours ch0 again
    rand_ops();
    ch0_req = 1'b1;
    ch1_req = 1'b1;
    serve(6, 1'b0, W'($urandom), W'($urandom));
    serve(6, 1'b0, W'($urandom), W'($urandom));

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
